// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius level/speed controller.
package genius_pkg;

    localparam int unsigned LEVEL_W              = 2;
    localparam int unsigned DEF_MAX_LEVEL        = 3;
    localparam int unsigned DEF_ROUNDS_PER_LEVEL = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        PENDING = 2'd2
    } state_e;

    function automatic logic [LEVEL_W-1:0] clamp_level(
        input logic [LEVEL_W-1:0] lvl,
        input logic [LEVEL_W-1:0] max_lvl
    );
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

endpackage

// File: rtl/genius_edge_sync.sv
// Synchronises an asynchronous level into CLK and emits a registered one-cycle pulse
// on each synchronised rising edge (latency SYNC_STAGES+1 cycles).
module genius_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   r_rise;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_dly  <= w_synced;
            r_rise <= w_synced & ~r_dly;
        end
    end

    assign rise_pulse = r_rise;

endmodule

// File: rtl/genius_level_ctrl.sv
// Genius difficulty controller: counts won rounds, promotes the rate-mux level only right
// after a CLKHZ rising edge. Optional manual level load: define GENIUS_LEVEL_MANUAL_EN.
module genius_level_ctrl
    import genius_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_LEVEL = DEF_ROUNDS_PER_LEVEL,
    parameter int unsigned MAX_LEVEL        = DEF_MAX_LEVEL,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               round_ok,
    input  logic               fail,
    input  logic               clkhz_in,
`ifdef GENIUS_LEVEL_MANUAL_EN
    input  logic               man_en,
    input  logic [LEVEL_W-1:0] man_level,
`endif
    output logic [LEVEL_W-1:0] level,
    output logic               tick,
    output logic               level_up,
    output logic               playing
);

    localparam int unsigned CNT_W = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ROUNDS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_level_up;
    logic               w_level_up_nxt;
    logic               w_tick;
    logic [LEVEL_W-1:0] w_restart_lvl;
    logic [LEVEL_W-1:0] w_idle_start_lvl;

    genius_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_clkhz_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .async_in  (clkhz_in),
        .rise_pulse(w_tick)
    );

`ifdef GENIUS_LEVEL_MANUAL_EN
    logic [LEVEL_W-1:0] w_man_lvl;
    assign w_man_lvl        = clamp_level(man_level, LVL_MAX);
    assign w_restart_lvl    = man_en ? w_man_lvl : '0;
    // Start from IDLE keeps whatever was manually loaded there.
    assign w_idle_start_lvl = man_en ? w_man_lvl : r_level;
`else
    assign w_restart_lvl    = '0;
    assign w_idle_start_lvl = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_level    <= '0;
            r_cnt      <= '0;
            r_level_up <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_cnt      <= w_cnt_nxt;
            r_level_up <= w_level_up_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_level_nxt    = r_level;
        w_cnt_nxt      = r_cnt;
        w_level_up_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
`ifdef GENIUS_LEVEL_MANUAL_EN
                if (man_en) begin
                    w_level_nxt = w_man_lvl;
                end
`endif
                if (start) begin
                    w_state_nxt = PLAY;
                    w_level_nxt = w_idle_start_lvl;
                    w_cnt_nxt   = '0;
                end
            end
            PLAY: begin
                if (fail) begin
                    w_state_nxt = IDLE;
                    w_level_nxt = w_restart_lvl;
                    w_cnt_nxt   = '0;
                end else if (start) begin
                    w_level_nxt = w_restart_lvl;
                    w_cnt_nxt   = '0;
                end else if (round_ok) begin
                    if (r_level == LVL_MAX) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = PENDING;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (fail) begin
                    w_state_nxt = IDLE;
                    w_level_nxt = w_restart_lvl;
                    w_cnt_nxt   = '0;
                end else if (start) begin
                    w_state_nxt = PLAY;
                    w_level_nxt = w_restart_lvl;
                    w_cnt_nxt   = '0;
                end else if (w_tick) begin
                    // Changing the mux select right after a CLKHZ rise avoids runt pulses.
                    w_state_nxt    = PLAY;
                    w_level_nxt    = r_level + LEVEL_W'(1);
                    w_level_up_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign level    = r_level;
    assign tick     = w_tick;
    assign level_up = r_level_up;
    assign playing  = (r_state != IDLE);

endmodule

// File: tb/tb_genius_level_ctrl.sv
// Directed self-checking bench for genius_level_ctrl (ROUNDS_PER_LEVEL=4, MAX_LEVEL=3).
module tb_genius_level_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       round_ok = 1'b0;
    logic       fail = 1'b0;
    logic       clkhz_in = 1'b0;
`ifdef GENIUS_LEVEL_MANUAL_EN
    logic       man_en = 1'b0;
    logic [1:0] man_level = 2'd0;
`endif
    logic [1:0] level;
    logic       tick;
    logic       level_up;
    logic       playing;

    int n_tests = 0;
    int n_fail  = 0;
    int up_cnt  = 0;

    genius_level_ctrl #(
        .ROUNDS_PER_LEVEL(4),
        .MAX_LEVEL       (3),
        .SYNC_STAGES     (2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .round_ok (round_ok),
        .fail     (fail),
        .clkhz_in (clkhz_in),
`ifdef GENIUS_LEVEL_MANUAL_EN
        .man_en   (man_en),
        .man_level(man_level),
`endif
        .level    (level),
        .tick     (tick),
        .level_up (level_up),
        .playing  (playing)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (level_up) up_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic rounds(input int n);
        repeat (n) begin
            round_ok = 1'b1;
            step(1);
            round_ok = 1'b0;
        end
    endtask

    // One CLKHZ rising edge, long enough for the synchroniser plus settle time.
    task automatic clkhz_edge();
        clkhz_in = 1'b1;
        step(4);
        clkhz_in = 1'b0;
        step(4);
    endtask

    task automatic promote();
        rounds(4);
        clkhz_edge();
    endtask

    initial begin
        // Reset with clkhz toggling
        for (int i = 0; i < 6; i++) begin
            clkhz_in = ~clkhz_in;
            step(1);
        end
        check("rst_level", 32'(level), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_level_up", 32'(level_up), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        clkhz_in = 1'b0;
        step(2);
        RST_N = 1'b1;
        step(4);
        check("idle_tick", 32'(tick), 32'd0);

        // Tick latency SYNC_STAGES+1 and width 1
        clkhz_in = 1'b1;
        step(1);
        check("tick_lat1", 32'(tick), 32'd0);
        step(1);
        check("tick_lat2", 32'(tick), 32'd0);
        step(1);
        check("tick_lat3", 32'(tick), 32'd1);
        step(1);
        check("tick_width", 32'(tick), 32'd0);
        clkhz_in = 1'b0;
        step(4);

        // First promotion waits for a CLKHZ edge
        pulse_start();
        check("start_playing", 32'(playing), 32'd1);
        check("start_level", 32'(level), 32'd0);
        rounds(4);
        step(4);
        check("pend_playing", 32'(playing), 32'd1);
        check("pend_level", 32'(level), 32'd0);
        check("pend_no_up", 32'(level_up), 32'd0);
        clkhz_in = 1'b1;
        step(3);
        check("pend_tick", 32'(tick), 32'd1);
        check("pend_level_at_tick", 32'(level), 32'd0);
        step(1);
        check("promo_level", 32'(level), 32'd1);
        check("promo_up", 32'(level_up), 32'd1);
        step(1);
        check("promo_up_width", 32'(level_up), 32'd0);
        clkhz_in = 1'b0;
        step(4);
        check("up_cnt_1", 32'(up_cnt), 32'd1);

        // Step to 2, 3, then saturate
        promote();
        check("level_2", 32'(level), 32'd2);
        promote();
        check("level_3", 32'(level), 32'd3);
        for (int i = 0; i < 8; i++) begin
            clkhz_in = ~clkhz_in;
            rounds(1);
        end
        clkhz_in = 1'b0;
        step(6);
        check("sat_level", 32'(level), 32'd3);
        check("sat_no_up", 32'(up_cnt), 32'd3);
        check("sat_playing", 32'(playing), 32'd1);

        // Start mid-PLAY at level 2 clears level and round count
        pulse_start();
        check("restart_level", 32'(level), 32'd0);
        promote();
        promote();
        check("restart_lvl2", 32'(level), 32'd2);
        rounds(1);
        pulse_start();
        check("mid_start_level", 32'(level), 32'd0);
        check("mid_start_playing", 32'(playing), 32'd1);
        rounds(3);
        clkhz_edge();
        check("cnt_cleared", 32'(level), 32'd0);
        rounds(1);
        clkhz_edge();
        check("cnt_fourth", 32'(level), 32'd1);
        check("up_cnt_6", 32'(up_cnt), 32'd6);

        // fail + round_ok in PENDING
        rounds(4);
        fail = 1'b1;
        round_ok = 1'b1;
        step(1);
        fail = 1'b0;
        round_ok = 1'b0;
        check("fail_playing", 32'(playing), 32'd0);
        check("fail_level", 32'(level), 32'd0);
        clkhz_edge();
        check("fail_no_promo", 32'(level), 32'd0);
        check("fail_no_up", 32'(up_cnt), 32'd6);
        rounds(1);
        check("idle_round_ignored", 32'(playing), 32'd0);

        // Reset mid-PENDING drops the promotion
        pulse_start();
        rounds(4);
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        check("rstpend_playing", 32'(playing), 32'd0);
        clkhz_edge();
        check("rstpend_level", 32'(level), 32'd0);
        check("rstpend_no_up", 32'(up_cnt), 32'd6);

`ifdef GENIUS_LEVEL_MANUAL_EN
        man_en = 1'b1;
        man_level = 2'd3;
        step(1);
        check("man_load3", 32'(level), 32'd3);
        man_level = 2'd2;
        step(1);
        check("man_load2", 32'(level), 32'd2);
        pulse_start();
        man_en = 1'b0;
        check("man_start_level", 32'(level), 32'd2);
        check("man_start_playing", 32'(playing), 32'd1);
        promote();
        check("man_promo", 32'(level), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
